// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared FSM encoding and carry-save tree sizing helpers
// Purpose: state type for the accumulator FSM and constant functions that size
//          the 3:2 reduction tree at elaboration time.
// Ports:   none (package).
package csa_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_OUTPUT  = 2'd2
  } state_t;

  // Vector count remaining after l levels of 3:2 reduction starting from n.
  // Each level turns every full group of three into two; leftovers pass through.
  function automatic int csa_count(input int n, input int l);
    int c;
    c = n;
    for (int k = 0; k < l; k++) begin
      if (c > 2) c = c - c / 3;
    end
    return c;
  endfunction

  // Number of 3:2 levels needed to bring n vectors down to two.
  function automatic int csa_levels(input int n);
    int c;
    int lv;
    c  = n;
    lv = 0;
    while (c > 2) begin
      c  = c - c / 3;
      lv = lv + 1;
    end
    return lv;
  endfunction

endpackage

// File: rtl/csa_accumulator_if.sv
// rtl/csa_accumulator_if.sv - input-beat and result handshake bundle
// Purpose: groups the operand stream and result stream of csa_accumulator.
// Ports:   in_valid/in_ready/in_data/in_signed/in_last (beat stream into the block),
//          out_valid/out_ready/out_data (result stream out of the block).
//          master = upstream/downstream side, slave = accumulator side.
interface csa_accumulator_if #(
  parameter int NUM_IN    = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 24
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NUM_IN*IN_WIDTH-1:0]   in_data;
  logic                         in_signed;
  logic                         in_last;
  logic                         out_valid;
  logic                         out_ready;
  logic [ACC_WIDTH-1:0]         out_data;

  modport master (
    output in_valid, in_data, in_signed, in_last, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_last, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/csa_3to2.sv
// rtl/csa_3to2.sv - word-wide row of 3:2 full adders
// Purpose: compresses three W-bit vectors into a sum and a carry vector.
// Ports:   i_a, i_b, i_c (W) operands; o_sum (W) bitwise sum;
//          o_carry (W) majority shifted left one, MSB dropped.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_c,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);
  logic [W-1:0] w_maj;

  assign o_sum   = i_a ^ i_b ^ i_c;
  assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
  assign o_carry = w_maj << 1;
endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - streaming multi-operand carry-save accumulator
// Purpose: each accepted beat folds NUM_IN operands into a stored sum/carry pair
//          through a 3:2 tree; the last beat of a group triggers one carry-propagate
//          add whose result is held until downstream accepts it.
// Ports:   clk (rising edge), reset (sync, active-high),
//          bus (csa_accumulator_if.slave): beat stream in, result stream out.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  csa_accumulator_if.slave     bus
);
  localparam int NV   = NUM_IN + 2;
  localparam int NLEV = csa_levels(NV);

  state_t               r_state;
  logic [ACC_WIDTH-1:0] r_acc_sum;
  logic [ACC_WIDTH-1:0] r_acc_carry;
  logic                 r_out_valid;
  logic [ACC_WIDTH-1:0] r_out_data;

  logic                 w_accept;
  logic [ACC_WIDTH-1:0] w_tree_sum;
  logic [ACC_WIDTH-1:0] w_tree_carry;

  // Level l of the tree occupies w_vec[l][0 .. csa_count(NV,l)-1]; the tail
  // of each row is tied off so every element has exactly one driver.
  logic [ACC_WIDTH-1:0] w_vec [NLEV+1][NV];

  for (genvar l = 0; l <= NLEV; l++) begin : g_lvl
    localparam int CNT = csa_count(NV, l);

    if (l == 0) begin : g_src
      for (genvar i = 0; i < NUM_IN; i++) begin : g_op
        logic [IN_WIDTH-1:0]         w_op;
        logic signed [ACC_WIDTH-1:0] w_sx;
        logic [ACC_WIDTH-1:0]        w_zx;
        assign w_op        = bus.in_data[i*IN_WIDTH +: IN_WIDTH];
        assign w_sx        = ACC_WIDTH'($signed(w_op));
        assign w_zx        = ACC_WIDTH'(w_op);
        assign w_vec[0][i] = bus.in_signed ? w_sx : w_zx;
      end
      assign w_vec[0][NUM_IN]   = r_acc_sum;
      assign w_vec[0][NUM_IN+1] = r_acc_carry;
    end else begin : g_red
      localparam int PREV = csa_count(NV, l - 1);
      localparam int NG   = PREV / 3;
      for (genvar g = 0; g < NG; g++) begin : g_row
        csa_3to2 #(.W(ACC_WIDTH)) u_row (
          .i_a     (w_vec[l-1][3*g]),
          .i_b     (w_vec[l-1][3*g+1]),
          .i_c     (w_vec[l-1][3*g+2]),
          .o_sum   (w_vec[l][2*g]),
          .o_carry (w_vec[l][2*g+1])
        );
      end
      for (genvar r = 0; r < PREV % 3; r++) begin : g_pass
        assign w_vec[l][2*NG+r] = w_vec[l-1][3*NG+r];
      end
    end

    for (genvar j = CNT; j < NV; j++) begin : g_tie
      assign w_vec[l][j] = '0;
    end
  end

  assign w_tree_sum   = w_vec[NLEV][0];
  assign w_tree_carry = w_vec[NLEV][1];

  // In OUTPUT the accumulator is already cleared, so a beat accepted alongside
  // the result handshake starts the next group from zero.
  assign bus.in_ready  = (r_state == ST_ACCUM) ||
                         ((r_state == ST_OUTPUT) && bus.out_ready);
  assign w_accept      = bus.in_valid && bus.in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ACCUM;
      r_acc_sum   <= '0;
      r_acc_carry <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc_sum   <= w_tree_sum;
            r_acc_carry <= w_tree_carry;
            if (bus.in_last) r_state <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          r_out_data  <= r_acc_sum + r_acc_carry;
          r_acc_sum   <= '0;
          r_acc_carry <= '0;
          r_out_valid <= 1'b1;
          r_state     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_ACCUM;
            if (w_accept) begin
              r_acc_sum   <= w_tree_sum;
              r_acc_carry <= w_tree_carry;
              if (bus.in_last) r_state <= ST_RESOLVE;
            end
          end
        end
        default: begin
          r_state     <= ST_ACCUM;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
